vx_mem_cacheline_loader: RTL and testbench
==========================================

Name: vx_mem_cacheline_loader

Overview:
Slave-side consumer of the cacheline load handshake. Accepts typed cachelines (instruction or data) from the load master and serializes each into single-word writes on a backing-memory write port. Keeps one independent, auto-incrementing address pointer per cacheline type. Sits between the stimulus-side load master and the memory model that feeds the Vortex core.

Parameters:
LINE_WORDS, 4, 32-bit words per cacheline (>=1)
ADDR_W, 32, memory byte-address width
INSTR_BASE, 32'h8000_0000, first byte address of the instruction region
DATA_BASE, 32'h9000_0000, first byte address of the data region
REGION_BYTES, 32'h0001_0000, size of each region; must be a multiple of LINE_WORDS*4

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
load_valid  in  1  master offers a cacheline
load_ready  out  1  loader can accept a cacheline
cacheline_type  in  2  cacheline_type_t: INSTR=0, DATA=1, 2/3 reserved
cacheline  in  LINE_WORDS*32  line payload; word 0 in bits [31:0]
mem_wr_en  out  1  write request valid
mem_wr_ready  in  1  memory accepts the write this cycle
mem_wr_addr  out  ADDR_W  byte address, 4-byte aligned
mem_wr_data  out  32  write word
busy  out  1  serialization in progress
lines_loaded  out  16  count of lines fully written; wraps
bad_type_cnt  out  8  count of reserved-type lines dropped; saturates at 255

Behaviour:
- Clock is clk. Reset is asynchronous, active-high; all state is cleared on reset assertion, independent of clk.
- Reset values: state=IDLE, load_ready=0 while reset is high, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, busy=0, both counters 0, instr_ptr=INSTR_BASE, data_ptr=DATA_BASE.
- FSM IDLE:
  - load_ready=1 (registered, deasserted during reset).
  - Handshake = load_valid && load_ready.
  - On a valid-type handshake: latch cacheline, latch type, capture the selected pointer into line_base, set word_idx=0, go to WRITE.
  - On a reserved-type handshake: drop the line, increment bad_type_cnt (saturating), remain in IDLE with load_ready=1. No pointer change and no write.
- FSM WRITE:
  - load_ready=0, busy=1, mem_wr_en=1.
  - mem_wr_addr = line_base + 4*word_idx; mem_wr_data = latched word[word_idx].
  - Address and data are held stable until mem_wr_ready=1.
  - Each cycle with mem_wr_en && mem_wr_ready: word_idx++.
  - When the last word (idx LINE_WORDS-1) is accepted: lines_loaded++, advance the selected pointer by LINE_WORDS*4, return to IDLE.
  - First write is presented the cycle after the handshake. With mem_wr_ready held at 1, the line takes LINE_WORDS cycles and load_ready reasserts the cycle after the last accept. Back-to-back throughput is 1 line per LINE_WORDS+1 cycles.
- Pointer wrap: if ptr + LINE_WORDS*4 - base == REGION_BYTES, the pointer returns to base. The two pointers never cross regions.
- load_valid with load_ready=0: ignored. The master must hold its payload until the handshake completes.
- Reset mid-WRITE: the partial line is abandoned (words already written stay in memory), pointers return to their bases, lines_loaded is not incremented.
- Payload or type changing while in WRITE: no effect, because the latched copy is used.

Decomposition:
- Shared tb package (VX_tb_common_pkg) holds cacheline_type_t enum (CL_INSTR, CL_DATA), the LINE_WORDS/word-width constants, risc_v_cacheline_t, and the default INSTR_BASE/DATA_BASE/REGION_BYTES.
- One natural sub-module: vx_line_addr_ptr (per-type pointer register with base, line-step increment, region wrap). Instantiate it twice.
- The top-level ports connect directly to the slave modport of the load interface.

Test Plan:
- Single INSTR line {1,2,3,4}, mem_wr_ready=1 -> writes (0x80000000,1)(…04,2)(…08,3)(…0C,4) on 4 consecutive cycles; lines_loaded=1; load_ready high 1 cycle after the last write.
- INSTR line then DATA line then INSTR line -> DATA written at 0x90000000; second INSTR written at 0x80000010; instruction and data pointers stay independent.
- mem_wr_ready toggling 1,0,0,1,1,0,1 -> each word is held stable while stalled; exactly 4 writes with correct addresses; no duplicate or skipped words.
- cacheline_type=3 with valid -> no mem_wr_en; bad_type_cnt=1; load_ready stays 1; next INSTR line is still written at 0x80000000.
- REGION_BYTES=32, three INSTR lines -> third line is written at 0x80000000 (wrap).
- Reset asserted after 2 of 4 words are accepted -> mem_wr_en drops immediately; lines_loaded=0; next line is written at the base address.

Source files
------------

// File: rtl/vx_mem_cacheline_loader_pkg.sv
// Shared types and defaults for the cacheline loader: line type encoding,
// FSM state encoding and the default memory map.
package vx_mem_cacheline_loader_pkg;

    typedef enum logic [1:0] {
        CL_INSTR = 2'd0,
        CL_DATA  = 2'd1,
        CL_RSVD2 = 2'd2,
        CL_RSVD3 = 2'd3
    } cacheline_type_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } loader_state_t;

    localparam int          WORD_W           = 32;
    localparam int          DEF_LINE_WORDS   = 4;
    localparam logic [31:0] DEF_INSTR_BASE   = 32'h8000_0000;
    localparam logic [31:0] DEF_DATA_BASE    = 32'h9000_0000;
    localparam logic [31:0] DEF_REGION_BYTES = 32'h0001_0000;

    function automatic logic type_is_valid(input logic [1:0] t);
        return (t == CL_INSTR) || (t == CL_DATA);
    endfunction

endpackage

// File: rtl/vx_mem_cacheline_loader_ptr.sv
// Per-type write pointer: starts at its region base, steps one line per
// completed cacheline and wraps back to the base at the end of the region.
module vx_line_addr_ptr #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE         = '0,
    parameter logic [ADDR_W-1:0] STEP         = ADDR_W'(16),
    parameter logic [ADDR_W-1:0] REGION_BYTES = ADDR_W'(32'h0001_0000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] next_ptr;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        next_ptr = ptr + STEP;
        if (next_ptr - BASE == REGION_BYTES) begin
            next_ptr = BASE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= BASE;
        end else if (advance) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/vx_mem_cacheline_loader.sv
// Cacheline load slave: accepts typed lines and serializes them into 32-bit
// writes on the backing-memory port, one address pointer per line type.
module vx_mem_cacheline_loader
    import vx_mem_cacheline_loader_pkg::*;
#(
    parameter int                LINE_WORDS   = DEF_LINE_WORDS,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] INSTR_BASE   = DEF_INSTR_BASE,
    parameter logic [ADDR_W-1:0] DATA_BASE    = DEF_DATA_BASE,
    parameter logic [ADDR_W-1:0] REGION_BYTES = DEF_REGION_BYTES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [1:0]                 cacheline_type,
    input  logic [LINE_WORDS*32-1:0]   cacheline,
    output logic                       mem_wr_en,
    input  logic                       mem_wr_ready,
    output logic [ADDR_W-1:0]          mem_wr_addr,
    output logic [31:0]                mem_wr_data,
    output logic                       busy,
    output logic [15:0]                lines_loaded,
    output logic [7:0]                 bad_type_cnt
);

    localparam int                IDX_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_WORDS * 4);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);

    loader_state_t                      state, state_next;
    logic [LINE_WORDS-1:0][WORD_W-1:0]  line_q;
    cacheline_type_t                    type_q;
    logic [ADDR_W-1:0]                  line_base;
    logic [IDX_W-1:0]                   word_idx;
    logic [ADDR_W-1:0]                  instr_ptr, data_ptr;

    logic handshake, good_hs, bad_hs, word_accept, last_accept;

    assign handshake   = load_valid && load_ready;
    assign good_hs     = handshake && type_is_valid(cacheline_type);
    assign bad_hs      = handshake && !type_is_valid(cacheline_type);
    assign word_accept = (state == ST_WRITE) && mem_wr_ready;
    assign last_accept = word_accept && (word_idx == LAST_IDX);

    vx_line_addr_ptr #(
        .ADDR_W(ADDR_W), .BASE(INSTR_BASE), .STEP(LINE_STEP), .REGION_BYTES(REGION_BYTES)
    ) u_instr_ptr (
        .clk(clk), .reset(reset),
        .advance(last_accept && (type_q == CL_INSTR)),
        .ptr(instr_ptr)
    );

    vx_line_addr_ptr #(
        .ADDR_W(ADDR_W), .BASE(DATA_BASE), .STEP(LINE_STEP), .REGION_BYTES(REGION_BYTES)
    ) u_data_ptr (
        .clk(clk), .reset(reset),
        .advance(last_accept && (type_q == CL_DATA)),
        .ptr(data_ptr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (good_hs)     state_next = ST_WRITE;
            ST_WRITE: if (last_accept) state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        busy        = 1'b0;
        if (state == ST_WRITE) begin
            mem_wr_en   = 1'b1;
            busy        = 1'b1;
            mem_wr_addr = line_base + ADDR_W'({word_idx, 2'b00});
            mem_wr_data = line_q[word_idx];
        end
    end

    // NOTE: the line buffer is a handful of flops, so it is cleared on reset with the rest of the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_ready   <= 1'b0;
            line_q       <= '0;
            type_q       <= CL_INSTR;
            line_base    <= '0;
            word_idx     <= '0;
            lines_loaded <= '0;
            bad_type_cnt <= '0;
        end else begin
            // Ready is registered: it drops the cycle a line is taken and
            // returns the cycle after its last word is accepted.
            load_ready <= (state_next == ST_IDLE);
            if (good_hs) begin
                line_q    <= cacheline;
                type_q    <= cacheline_type_t'(cacheline_type);
                line_base <= (cacheline_type == CL_INSTR) ? instr_ptr : data_ptr;
                word_idx  <= '0;
            end else if (word_accept) begin
                word_idx <= word_idx + 1'b1;
            end
            if (last_accept) begin
                lines_loaded <= lines_loaded + 16'd1;
            end
            if (bad_hs && (bad_type_cnt != 8'hFF)) begin
                bad_type_cnt <= bad_type_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vx_mem_cacheline_loader.sv
// Scoreboard bench for the cacheline loader: two instances (default region and
// a 32-byte region to exercise pointer wrap) share the same stimulus.
module tb_vx_mem_cacheline_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_valid = 1'b0;
    logic [1:0]   cacheline_type = 2'd0;
    logic [127:0] cacheline = '0;
    logic         mem_wr_ready = 1'b1;

    logic         load_ready0, mem_wr_en0, busy0;
    logic [31:0]  mem_wr_addr0, mem_wr_data0;
    logic [15:0]  lines_loaded0;
    logic [7:0]   bad_type_cnt0;

    logic         load_ready1, mem_wr_en1, busy1;
    logic [31:0]  mem_wr_addr1, mem_wr_data1;
    logic [15:0]  lines_loaded1;
    logic [7:0]   bad_type_cnt1;

    int tests = 0;
    int fails = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic [31:0] iptr0, dptr0, iptr1, dptr1;
    int          lines_exp, bad_exp;

    always #5 clk = ~clk;

    vx_mem_cacheline_loader dut0 (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready0),
        .cacheline_type(cacheline_type), .cacheline(cacheline),
        .mem_wr_en(mem_wr_en0), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr0), .mem_wr_data(mem_wr_data0),
        .busy(busy0), .lines_loaded(lines_loaded0), .bad_type_cnt(bad_type_cnt0)
    );

    vx_mem_cacheline_loader #(.REGION_BYTES(32'h20)) dut1 (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready1),
        .cacheline_type(cacheline_type), .cacheline(cacheline),
        .mem_wr_en(mem_wr_en1), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr1), .mem_wr_data(mem_wr_data1),
        .busy(busy1), .lines_loaded(lines_loaded1), .bad_type_cnt(bad_type_cnt1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] step_ptr(input logic [31:0] p, input logic [31:0] base,
                                             input logic [31:0] region);
        logic [31:0] n;
        n = p + 32'd16;
        if (n - base == region) n = base;
        return n;
    endfunction

    task automatic model_reset();
        iptr0 = 32'h8000_0000; dptr0 = 32'h9000_0000;
        iptr1 = 32'h8000_0000; dptr1 = 32'h9000_0000;
        lines_exp = 0;
        bad_exp   = 0;
    endtask

    // Offers one line, pushes the n_push words the DUT is expected to write.
    task automatic send_line(input logic [1:0] t, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3, input int n_push);
        logic [31:0] w[4];
        logic [31:0] b0, b1;
        int n = 0;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        while (!load_ready0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("handshake_ready", {31'd0, load_ready0}, 32'd1);
        cacheline_type = t;
        cacheline      = {w3, w2, w1, w0};
        load_valid     = 1'b1;
        if (t <= 2'd1) begin
            b0 = (t == 2'd0) ? iptr0 : dptr0;
            b1 = (t == 2'd0) ? iptr1 : dptr1;
            for (int k = 0; k < n_push; k++) begin
                q0.push_back('{addr: b0 + 32'(4 * k), data: w[k]});
                q1.push_back('{addr: b1 + 32'(4 * k), data: w[k]});
            end
            if (n_push == 4) begin
                lines_exp++;
                if (t == 2'd0) begin
                    iptr0 = step_ptr(iptr0, 32'h8000_0000, 32'h0001_0000);
                    iptr1 = step_ptr(iptr1, 32'h8000_0000, 32'h20);
                end else begin
                    dptr0 = step_ptr(dptr0, 32'h9000_0000, 32'h0001_0000);
                    dptr1 = step_ptr(dptr1, 32'h9000_0000, 32'h20);
                end
            end
        end else begin
            bad_exp++;
        end
        @(posedge clk); #1;
        load_valid     = 1'b0;
        cacheline      = {4{32'hDEAD_BEEF}};
        cacheline_type = 2'd3;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, q0.size() + q1.size(), 32'd0);
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    logic        stalled0 = 1'b0, stalled1 = 1'b0;
    logic [31:0] held_addr0, held_data0, held_addr1, held_data1;

    always @(negedge clk) begin
        exp_t e;
        if (mem_wr_en0) begin
            if (stalled0) begin
                check("stall_hold_addr0", mem_wr_addr0, held_addr0);
                check("stall_hold_data0", mem_wr_data0, held_data0);
            end
            if (mem_wr_ready) begin
                stalled0 = 1'b0;
                if (q0.size() == 0) begin
                    check("unexpected_write0", mem_wr_addr0, 32'hFFFF_FFFF);
                end else begin
                    e = q0.pop_front();
                    check("wr_addr0", mem_wr_addr0, e.addr);
                    check("wr_data0", mem_wr_data0, e.data);
                end
            end else begin
                stalled0   = 1'b1;
                held_addr0 = mem_wr_addr0;
                held_data0 = mem_wr_data0;
            end
        end else begin
            stalled0 = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mem_wr_en1) begin
            if (stalled1) begin
                check("stall_hold_addr1", mem_wr_addr1, held_addr1);
                check("stall_hold_data1", mem_wr_data1, held_data1);
            end
            if (mem_wr_ready) begin
                stalled1 = 1'b0;
                if (q1.size() == 0) begin
                    check("unexpected_write1", mem_wr_addr1, 32'hFFFF_FFFF);
                end else begin
                    e = q1.pop_front();
                    check("wr_addr1", mem_wr_addr1, e.addr);
                    check("wr_data1", mem_wr_data1, e.data);
                end
            end else begin
                stalled1   = 1'b1;
                held_addr1 = mem_wr_addr1;
                held_data1 = mem_wr_data1;
            end
        end else begin
            stalled1 = 1'b0;
        end
    end

    localparam bit STALL_PAT [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        model_reset();
        #12;
        check("rst_load_ready", {31'd0, load_ready0}, 32'd0);
        check("rst_wr_en",      {31'd0, mem_wr_en0}, 32'd0);
        check("rst_wr_addr",    mem_wr_addr0, 32'd0);
        check("rst_wr_data",    mem_wr_data0, 32'd0);
        check("rst_busy",       {31'd0, busy0}, 32'd0);
        check("rst_lines",      {16'd0, lines_loaded0}, 32'd0);
        check("rst_bad",        {24'd0, bad_type_cnt0}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single INSTR line, ready always high: timing of load_ready.
        send_line(2'd0, 32'd1, 32'd2, 32'd3, 32'd4, 4);
        check("t1_ready_low", {31'd0, load_ready0}, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("t1_ready_last", {31'd0, load_ready0}, 32'd0);
        check("t1_busy_last",  {31'd0, busy0}, 32'd1);
        @(posedge clk); #1;
        check("t1_ready_back", {31'd0, load_ready0}, 32'd1);
        check("t1_busy_done",  {31'd0, busy0}, 32'd0);
        check("t1_lines",      {16'd0, lines_loaded0}, 32'd1);
        drain("t1_drain");

        // INSTR, DATA, INSTR: independent pointers (dut1 wraps on the third).
        send_line(2'd0, 32'h11, 32'h12, 32'h13, 32'h14, 4);
        send_line(2'd1, 32'h21, 32'h22, 32'h23, 32'h24, 4);
        send_line(2'd0, 32'h31, 32'h32, 32'h33, 32'h34, 4);
        drain("t2_drain");
        check("t2_lines", {16'd0, lines_loaded0}, 32'(lines_exp));

        // Stalled writes: ready pattern 1,0,0,1,1,0,1.
        mem_wr_ready = 1'b0;
        send_line(2'd1, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4);
        for (int i = 0; i < 7; i++) begin
            mem_wr_ready = STALL_PAT[i];
            @(posedge clk); #1;
        end
        check("t3_done_ready", {31'd0, load_ready0}, 32'd1);
        mem_wr_ready = 1'b1;
        drain("t3_drain");
        check("t3_lines", {16'd0, lines_loaded0}, 32'(lines_exp));

        // Reset after two of four words accepted.
        mem_wr_ready = 1'b0;
        send_line(2'd0, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 2);
        mem_wr_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        check("t4_wr_en_drop", {31'd0, mem_wr_en0}, 32'd0);
        check("t4_lines",      {16'd0, lines_loaded0}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        check("t4_queue_empty", q0.size(), 32'd0);

        // Reserved type dropped, then INSTR lands at base.
        @(posedge clk); #1;
        send_line(2'd3, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 0);
        check("t5_no_write",   {31'd0, mem_wr_en0}, 32'd0);
        check("t5_ready",      {31'd0, load_ready0}, 32'd1);
        check("t5_bad_cnt",    {24'd0, bad_type_cnt0}, 32'(bad_exp));
        send_line(2'd0, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 4);
        drain("t5_drain");

        // Wrap: fresh reset, three INSTR lines; dut1 region holds two lines.
        pulse_reset();
        send_line(2'd0, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 4);
        send_line(2'd0, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 4);
        send_line(2'd0, 32'h50, 32'h51, 32'h52, 32'h53, 4);
        drain("t6_drain");
        check("t6_lines1", {16'd0, lines_loaded1}, 32'd3);
        check("t6_iptr1",  iptr1, 32'h8000_0010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
